pulse_sequence_checker: RTL and testbench

Receive-side monitor for the 16-phase one-hot timing bus T[0:15] that drives the control unit. Encodes the active phase to a 4-bit step index and locks onto the T0→T1→…→T15→T0 sequence. Flags dropouts, multi-hot words and skipped phases, and counts completed instruction cycles. Sits beside the control decoder on the T bus and is the consuming end of the timing-pulse interface.

---
 rtl/pulse_sequence_checker.sv | 170 +++++++++++++++++
 tb/tb_pulse_sequence_checker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_sequence_checker.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_sequence_checker
//  Purpose  : Receive-side monitor for the 16-phase one-hot timing bus.
//             Encodes the active phase, locks onto the T0..T15 ring, flags
//             dropouts / multi-hot words / skipped phases and counts cycles.
//  Revision : 1.0  initial release
// ============================================================================
module pulse_sequence_checker #(
  parameter int LOCK_CNT = 4,
  parameter int CYC_W    = 16,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      t_in,
  input  logic             clr,
  output logic [3:0]       step,
  output logic             step_valid,
  output logic             locked,
  output logic             wrap_pulse,
  output logic [CYC_W-1:0] cycle_count,
  output logic             err_pulse,
  output logic [1:0]       err_kind,
  output logic [ERR_W-1:0] err_count
);

  // Lock threshold as a 4-bit value so it compares directly with the
  // matched-word counter.
  localparam logic [3:0]       c_lock    = 4'(LOCK_CNT);
  localparam logic [CYC_W-1:0] c_cyc_one = CYC_W'(1);
  localparam logic [ERR_W-1:0] c_err_one = ERR_W'(1);
  localparam logic [ERR_W-1:0] c_err_max = '1;

  // Error-kind codes reported on err_kind.
  localparam logic [1:0] c_kind_zero  = 2'd0;
  localparam logic [1:0] c_kind_multi = 2'd1;
  localparam logic [1:0] c_kind_skip  = 2'd2;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_t_q;    // registered bus word under classification
  logic [3:0]  r_exp;    // phase index expected next
  logic [3:0]  r_good;   // consecutive matched words while confirming

  logic [4:0]  w_ones;   // population count of r_t_q
  logic [3:0]  w_idx;    // index of the highest set bit of r_t_q
  logic        w_zero;
  logic        w_multi;
  logic        w_one;
  logic        w_match;  // one-hot and equal to the expected phase

  // Classify the registered word: population count and active index.
  always_comb begin
    w_ones = 5'd0;
    w_idx  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (r_t_q[i]) begin
        w_ones = w_ones + 5'd1;
        w_idx  = 4'(i);
      end
    end
    w_zero  = (w_ones == 5'd0);
    w_one   = (w_ones == 5'd1);
    w_multi = !w_zero && !w_one;
    w_match = w_one && (w_idx == r_exp);
  end

  // Input register, sequence FSM, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_t_q       <= 16'd0;
      r_state     <= ST_HUNT;
      r_exp       <= 4'd0;
      r_good      <= 4'd0;
      step        <= 4'd0;
      step_valid  <= 1'b0;
      locked      <= 1'b0;
      wrap_pulse  <= 1'b0;
      err_pulse   <= 1'b0;
      err_kind    <= c_kind_zero;
      cycle_count <= '0;
      err_count   <= '0;
    end else begin
      r_t_q      <= t_in;
      // The step encoder follows the bus in every state, locked or not.
      step       <= w_one ? w_idx : 4'd0;
      step_valid <= w_one;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;

      case (r_state)
        ST_HUNT: begin
          // Any clean one-hot word seeds the sequence; junk is ignored.
          if (w_one) begin
            r_exp  <= w_idx + 4'd1;
            r_good <= 4'd1;
            if (c_lock == 4'd1) begin
              r_state <= ST_LOCKED;
              locked  <= 1'b1;
            end else begin
              r_state <= ST_CONFIRM;
            end
          end
        end

        ST_CONFIRM: begin
          if (w_match) begin
            r_good <= r_good + 4'd1;
            r_exp  <= r_exp + 4'd1;
            if (r_good + 4'd1 == c_lock) begin
              r_state <= ST_LOCKED;
              locked  <= 1'b1;
            end
          end else begin
            // A wrong word is dropped, not used as a new seed; the
            // following word is judged under hunting rules.
            r_state <= ST_HUNT;
            r_good  <= 4'd0;
          end
        end

        ST_LOCKED: begin
          if (w_match) begin
            r_exp <= r_exp + 4'd1;
            // A matched T0 can only follow T15, i.e. one full ring.
            if (w_idx == 4'd0) begin
              wrap_pulse  <= 1'b1;
              cycle_count <= cycle_count + c_cyc_one;
            end
          end else begin
            err_pulse <= 1'b1;
            if (w_zero) begin
              err_kind <= c_kind_zero;
            end else if (w_multi) begin
              err_kind <= c_kind_multi;
            end else begin
              err_kind <= c_kind_skip;
            end
            if (err_count != c_err_max) begin
              err_count <= err_count + c_err_one;
            end
            r_state <= ST_HUNT;
            r_good  <= 4'd0;
            locked  <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_HUNT;
          r_good  <= 4'd0;
          locked  <= 1'b0;
        end
      endcase

      // Clear overrides any same-cycle increment; pulses are unaffected.
      if (clr) begin
        cycle_count <= '0;
        err_count   <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_sequence_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_sequence_checker
//  Purpose  : Self-checking bench for pulse_sequence_checker. Three instances
//             (default, 4-bit cycle counter, single-word lock with 3-bit
//             error counter) share one stimulus stream; each is compared
//             every cycle against a word-level sequence model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pulse_sequence_checker;

  logic        clk;
  logic        reset;
  logic        clr;
  logic [15:0] t_in;

  // Instance A: defaults
  logic [3:0]  a_step;  logic a_sv, a_locked, a_wrap, a_err;
  logic [1:0]  a_kind;  logic [15:0] a_cyc; logic [7:0] a_errc;
  // Instance B: CYC_W = 4
  logic [3:0]  b_step;  logic b_sv, b_locked, b_wrap, b_err;
  logic [1:0]  b_kind;  logic [3:0] b_cyc;  logic [7:0] b_errc;
  // Instance C: LOCK_CNT = 1, ERR_W = 3
  logic [3:0]  c_step;  logic c_sv, c_locked, c_wrap, c_err;
  logic [1:0]  c_kind;  logic [15:0] c_cyc; logic [2:0] c_errc;

  pulse_sequence_checker u_a (
    .clk(clk), .reset(reset), .t_in(t_in), .clr(clr),
    .step(a_step), .step_valid(a_sv), .locked(a_locked), .wrap_pulse(a_wrap),
    .cycle_count(a_cyc), .err_pulse(a_err), .err_kind(a_kind), .err_count(a_errc));

  pulse_sequence_checker #(.LOCK_CNT(4), .CYC_W(4), .ERR_W(8)) u_b (
    .clk(clk), .reset(reset), .t_in(t_in), .clr(clr),
    .step(b_step), .step_valid(b_sv), .locked(b_locked), .wrap_pulse(b_wrap),
    .cycle_count(b_cyc), .err_pulse(b_err), .err_kind(b_kind), .err_count(b_errc));

  pulse_sequence_checker #(.LOCK_CNT(1), .CYC_W(16), .ERR_W(3)) u_c (
    .clk(clk), .reset(reset), .t_in(t_in), .clr(clr),
    .step(c_step), .step_valid(c_sv), .locked(c_locked), .wrap_pulse(c_wrap),
    .cycle_count(c_cyc), .err_pulse(c_err), .err_kind(c_kind), .err_count(c_errc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Word-level model: a run length of consecutively sequenced one-hot words
  // plus the last accepted phase; lock is declared once the run is long
  // enough, and any break while locked is an error.
  typedef struct {
    bit locked;
    int run;
    int last;
    int cyc;
    int errc;
    int kind;
    bit wrap;
    bit err;
    int step;
    bit sv;
  } mdl_t;

  mdl_t        m_a, m_c;
  logic [15:0] m_tq;
  int          p;   // next ring phase to drive

  function automatic void mdl_reset(inout mdl_t m);
    m.locked = 0; m.run = 0; m.last = 0; m.cyc = 0; m.errc = 0;
    m.kind = 0; m.wrap = 0; m.err = 0; m.step = 0; m.sv = 0;
  endfunction

  function automatic void mdl_word(inout mdl_t m, input logic [15:0] q, input bit c,
                                   input int lock_cnt, input int emax);
    int n = $countones(q);
    int k = 0;
    bit seq;
    for (int i = 0; i < 16; i++) if (q[i]) k = i;
    seq    = (n == 1) && (k == (m.last + 1) % 16);
    m.wrap = 0;
    m.err  = 0;
    m.sv   = (n == 1);
    m.step = (n == 1) ? k : 0;
    if (m.locked) begin
      if (seq) begin
        m.last = k;
        if (k == 0) begin m.wrap = 1; m.cyc++; end
      end else begin
        m.err    = 1;
        m.kind   = (n == 0) ? 0 : (n > 1) ? 1 : 2;
        if (m.errc < emax) m.errc++;
        m.locked = 0;
        m.run    = 0;
      end
    end else if (m.run == 0) begin
      if (n == 1) begin
        m.run = 1; m.last = k; m.locked = (lock_cnt == 1);
      end
    end else if (seq) begin
      m.run++; m.last = k;
      if (m.run == lock_cnt) m.locked = 1;
    end else begin
      m.run = 0;
    end
    if (c) begin m.cyc = 0; m.errc = 0; end
  endfunction

  // One clock: drive inputs, advance the model across the edge, compare.
  task automatic cyc(input logic [15:0] w, input bit c, input bit r);
    @(negedge clk);
    t_in = w; clr = c; reset = r;
    @(posedge clk);
    if (r) begin
      mdl_reset(m_a); mdl_reset(m_c); m_tq = 16'd0;
    end else begin
      mdl_word(m_a, m_tq, c, 4, 255);
      mdl_word(m_c, m_tq, c, 1, 7);
      m_tq = w;
    end
    #1;
    chk("a_step",   a_step,   m_a.step);
    chk("a_valid",  a_sv,     m_a.sv);
    chk("a_locked", a_locked, m_a.locked);
    chk("a_wrap",   a_wrap,   m_a.wrap);
    chk("a_err",    a_err,    m_a.err);
    chk("a_kind",   a_kind,   m_a.kind);
    chk("a_cyc",    a_cyc,    m_a.cyc & 32'hFFFF);
    chk("a_errc",   a_errc,   m_a.errc);
    chk("b_locked", b_locked, m_a.locked);
    chk("b_cyc",    b_cyc,    m_a.cyc & 32'hF);
    chk("c_step",   c_step,   m_c.step);
    chk("c_locked", c_locked, m_c.locked);
    chk("c_wrap",   c_wrap,   m_c.wrap);
    chk("c_err",    c_err,    m_c.err);
    chk("c_kind",   c_kind,   m_c.kind);
    chk("c_cyc",    c_cyc,    m_c.cyc & 32'hFFFF);
    chk("c_errc",   c_errc,   m_c.errc);
    if (a_wrap && a_err) chk("a_wrap_err_excl", 1, 0);
  endtask

  task automatic ring(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(16'h0001 << p, 1'b0, 1'b0);
      p = (p + 1) % 16;
    end
  endtask

  initial begin
    logic [15:0] w;
    int a, r;
    t_in = 16'd0; clr = 1'b0; reset = 1'b1;
    m_tq = 16'd0; p = 0;
    mdl_reset(m_a); mdl_reset(m_c);

    // Reset with an idle bus
    cyc(16'd0, 0, 1);
    cyc(16'd0, 0, 1);
    chk("rst_locked", a_locked, 0);
    chk("rst_cyc",    a_cyc,    0);

    // Three full rings plus T0,T1 so the third wrap is visible
    ring(48);
    ring(2);
    chk("ring3_cyc",    a_cyc,    3);
    chk("ring3_locked", a_locked, 1);

    // Dropout while locked, then relock
    cyc(16'd0, 0, 0);
    ring(1);
    chk("drop_kind", a_kind, 0);
    chk("drop_errc", a_errc, 1);
    ring(8);

    // Multi-hot word while locked
    cyc(16'h0300, 0, 0);
    ring(1);
    chk("multi_kind",  a_kind, 1);
    chk("multi_valid", a_sv,   0);
    ring(8);

    // Skip: T5 directly after T3
    while (p != 4) ring(1);
    p = 5;
    ring(2);
    chk("skip_kind", a_kind, 2);
    chk("skip_errc", a_errc, 3);
    ring(8);

    // Saturate the error counter from a cleared value
    cyc(16'h0001 << p, 1, 0); p = (p + 1) % 16;
    for (int i = 0; i < 255; i++) begin
      cyc(16'd0, 0, 0);
      ring(4);
    end
    chk("sat_255", a_errc, 255);
    cyc(16'd0, 0, 0);
    ring(1);
    chk("sat_pulse", a_err,  1);
    chk("sat_hold",  a_errc, 255);
    ring(3);
    cyc(16'd0, 0, 0);
    cyc(16'h0001 << p, 1, 0); p = (p + 1) % 16;
    chk("clr_err_pulse", a_err,  1);
    chk("clr_err_count", a_errc, 0);
    ring(8);

    // Reset in the middle of the locked ring at T9
    while (p != 9) ring(1);
    cyc(16'h0200, 0, 1); p = 10;
    chk("midrst_locked", a_locked, 0);
    chk("midrst_err",    a_err,    0);
    ring(8);

    // clr together with a wrap, then 17 rings on the 4-bit counter
    while (p != 15) ring(1);
    ring(2);
    cyc(16'h0001 << p, 1, 0); p = (p + 1) % 16;
    chk("clr_wrap_pulse", a_wrap, 1);
    chk("clr_wrap_cnt",   b_cyc,  0);
    ring(272);
    chk("cyc4_wrap", b_cyc, 1);
    chk("cyc16_17",  a_cyc, 17);

    // Randomized traffic with faults, occasional clear and reset
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 78) begin
        w = 16'h0001 << p; p = (p + 1) % 16;
      end else if (r < 84) begin
        w = 16'd0;
      end else if (r < 90) begin
        a = $urandom_range(0, 15);
        w = (16'h0001 << a) | (16'h0001 << ((a + 1 + $urandom_range(0, 14)) % 16));
      end else if (r < 96) begin
        p = $urandom_range(0, 15);
        w = 16'h0001 << p; p = (p + 1) % 16;
      end else begin
        w = 16'($urandom);
      end
      cyc(w, ($urandom_range(0, 49) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
